// File: rtl/i2c_slave.sv
// I2C target: oversampled, glitch-filtered scl/sda with START/STOP detection,
// fixed 7-bit address match and byte-wide write/read handshakes to local logic.
module i2c_slave #(
  parameter logic [6:0] ADDRESS      = 7'h2A,
  parameter int         FILTER_DEPTH = 3
) (
  input  logic       clk_in,
  input  logic       reset,
  inout  wire        scl,
  inout  wire        sda,
  input  logic [7:0] data_tx,
  input  logic       data_nack,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       read_mode,
  output logic       selected,
  output logic       start_detected,
  output logic       stop_detected,
  output logic       nack_received
);

  localparam int CW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE_DATA,
    S_WRITE_ACK, S_READ_DATA, S_READ_ACK, S_IGNORE
  } state_t;

  logic [1:0]    r_scl_s, r_sda_s;
  logic          r_scl_f, r_sda_f, r_scl_prev, r_sda_prev;
  logic [CW-1:0] r_scl_cnt, r_sda_cnt;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_data_rx, w_data_rx_nxt;
  logic       r_phase, w_phase_nxt;
  logic       r_sda_low, w_sda_low_nxt;
  logic       r_read_mode, w_read_mode_nxt;
  logic       r_selected, w_selected_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_start, w_start_nxt;
  logic       r_stop, w_stop_nxt;
  logic       r_nack, w_nack_nxt;
  logic       w_tx_load;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;

  // A filtered line only follows the synchronised input after it has held a
  // new value for FILTER_DEPTH consecutive samples.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_scl_s    <= 2'b11;
      r_sda_s    <= 2'b11;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_scl_cnt  <= '0;
      r_sda_cnt  <= '0;
    end else begin
      r_scl_s    <= {r_scl_s[0], scl};
      r_sda_s    <= {r_sda_s[0], sda};
      r_scl_prev <= r_scl_f;
      r_sda_prev <= r_sda_f;
      if (r_scl_s[1] == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == CNT_MAX) begin
        r_scl_f   <= r_scl_s[1];
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 1'b1;
      end
      if (r_sda_s[1] == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == CNT_MAX) begin
        r_sda_f   <= r_sda_s[1];
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 1'b1;
      end
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_f & r_scl_prev;
  assign w_start    = r_scl_f & r_scl_prev & r_sda_prev & ~r_sda_f;
  assign w_stop     = r_scl_f & r_scl_prev & ~r_sda_prev & r_sda_f;
  assign w_byte     = {r_shift[6:0], r_sda_f};

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_data_rx   <= 8'h00;
      r_phase     <= 1'b0;
      r_sda_low   <= 1'b0;
      r_read_mode <= 1'b0;
      r_selected  <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      r_nack      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_data_rx   <= w_data_rx_nxt;
      r_phase     <= w_phase_nxt;
      r_sda_low   <= w_sda_low_nxt;
      r_read_mode <= w_read_mode_nxt;
      r_selected  <= w_selected_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_start     <= w_start_nxt;
      r_stop      <= w_stop_nxt;
      r_nack      <= w_nack_nxt;
    end
  end

  // r_phase splits each ACK state into "waiting for the slot" and "in the slot".
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_data_rx_nxt   = r_data_rx;
    w_phase_nxt     = r_phase;
    w_sda_low_nxt   = r_sda_low;
    w_read_mode_nxt = r_read_mode;
    w_selected_nxt  = r_selected;
    w_rx_valid_nxt  = 1'b0;
    w_start_nxt     = 1'b0;
    w_stop_nxt      = 1'b0;
    w_nack_nxt      = 1'b0;
    w_tx_load       = 1'b0;
    if (w_start) begin
      w_start_nxt    = 1'b1;
      w_bit_cnt_nxt  = 3'd0;
      w_sda_low_nxt  = 1'b0;
      w_selected_nxt = 1'b0;
      w_phase_nxt    = 1'b0;
      w_state_nxt    = S_ADDR;
    end else if (w_stop) begin
      w_stop_nxt     = 1'b1;
      w_sda_low_nxt  = 1'b0;
      w_selected_nxt = 1'b0;
      w_state_nxt    = S_IDLE;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            if (r_bit_cnt == 3'd7) begin
              w_bit_cnt_nxt = 3'd0;
              w_phase_nxt   = 1'b0;
              if (w_byte[7:1] == ADDRESS && w_byte[7:1] != 7'h00) begin
                w_read_mode_nxt = w_byte[0];
                w_state_nxt     = S_ADDR_ACK;
              end else begin
                w_state_nxt = S_IGNORE;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_phase_nxt    = 1'b1;
              w_sda_low_nxt  = 1'b1;
              w_selected_nxt = 1'b1;
            end else if (r_read_mode) begin
              w_tx_load     = 1'b1;
              w_shift_nxt   = {data_tx[6:0], 1'b0};
              w_sda_low_nxt = ~data_tx[7];
              w_bit_cnt_nxt = 3'd0;
              w_state_nxt   = S_READ_DATA;
            end else begin
              w_sda_low_nxt = 1'b0;
              w_bit_cnt_nxt = 3'd0;
              w_state_nxt   = S_WRITE_DATA;
            end
          end
        end
        S_WRITE_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            if (r_bit_cnt == 3'd7) begin
              w_data_rx_nxt  = w_byte;
              w_rx_valid_nxt = 1'b1;
              w_bit_cnt_nxt  = 3'd0;
              w_phase_nxt    = 1'b0;
              w_state_nxt    = S_WRITE_ACK;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
          end
        end
        S_WRITE_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_phase_nxt   = 1'b1;
              w_sda_low_nxt = ~data_nack;
            end else begin
              w_sda_low_nxt = 1'b0;
              w_state_nxt   = r_sda_low ? S_WRITE_DATA : S_IGNORE;
            end
          end
        end
        S_READ_DATA: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd7) begin
              w_sda_low_nxt = 1'b0;
              w_bit_cnt_nxt = 3'd0;
              w_phase_nxt   = 1'b0;
              w_state_nxt   = S_READ_ACK;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
              w_sda_low_nxt = ~r_shift[7];
              w_shift_nxt   = {r_shift[6:0], 1'b0};
            end
          end
        end
        S_READ_ACK: begin
          if (w_scl_rise) begin
            if (r_sda_f) begin
              w_nack_nxt  = 1'b1;
              w_state_nxt = S_IGNORE;
            end else begin
              w_phase_nxt = 1'b1;
            end
          end else if (w_scl_fall && r_phase) begin
            w_tx_load     = 1'b1;
            w_shift_nxt   = {data_tx[6:0], 1'b0};
            w_sda_low_nxt = ~data_tx[7];
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = S_READ_DATA;
          end
        end
        default: begin
          w_sda_low_nxt = 1'b0;
        end
      endcase
    end
  end

  assign scl            = 1'bz;
  assign sda            = r_sda_low ? 1'b0 : 1'bz;
  assign data_rx        = r_data_rx;
  assign rx_valid       = r_rx_valid;
  assign tx_load        = w_tx_load;
  assign read_mode      = r_read_mode;
  assign selected       = r_selected;
  assign start_detected = r_start;
  assign stop_detected  = r_stop;
  assign nack_received  = r_nack;

endmodule

// File: tb/tb_i2c_slave.sv
// Drives i2c_slave as a bus master and checks it against a transaction-level
// model of how an addressed target should ACK, receive and return bytes.
module tb_i2c_slave;

  localparam logic [6:0] ADDR = 7'h2A;
  localparam time Q = 200ns;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       m_scl, m_sda;
  wire        scl, sda;
  logic [7:0] data_tx;
  logic       data_nack;
  logic [7:0] data_rx;
  logic       rx_valid, tx_load, read_mode, selected;
  logic       start_detected, stop_detected, nack_received;

  int testsRun = 0;
  int testsFailed = 0;
  int rxCount = 0;
  int txCount = 0;
  int startCount = 0;
  int stopCount = 0;
  int nackCount = 0;
  logic [7:0] rxQ[$];

  assign scl = m_scl ? 1'bz : 1'b0;
  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (scl);
  pullup (sda);

  always #5ns clk_in = ~clk_in;

  i2c_slave #(.ADDRESS(ADDR), .FILTER_DEPTH(3)) dut (
    .clk_in(clk_in), .reset(reset), .scl(scl), .sda(sda),
    .data_tx(data_tx), .data_nack(data_nack), .data_rx(data_rx),
    .rx_valid(rx_valid), .tx_load(tx_load), .read_mode(read_mode),
    .selected(selected), .start_detected(start_detected),
    .stop_detected(stop_detected), .nack_received(nack_received)
  );

  always @(posedge clk_in) begin
    if (rx_valid) begin
      rxCount <= rxCount + 1;
      rxQ.push_back(data_rx);
    end
    if (tx_load)        txCount    <= txCount + 1;
    if (start_detected) startCount <= startCount + 1;
    if (stop_detected)  stopCount  <= stopCount + 1;
    if (nack_received)  nackCount  <= nackCount + 1;
  end

  task automatic bus_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
    #Q;
  endtask

  task automatic send_bit(input logic b, output logic sampled);
    m_sda = b; #Q;
    m_scl = 1'b1; #Q;
    sampled = sda; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, s);
    acked = (s === 1'b0);
  endtask

  // Next byte for the target goes onto data_tx before the ACK slot, where it is loaded.
  task automatic recv_byte(input logic masterAck, input logic [7:0] nextTx, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    data_tx = nextTx;
    send_bit(~masterAck, s);
  endtask

  task automatic test_reset();
    reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1; data_tx = 8'h00; data_nack = 1'b0;
    #23ns;
    testsRun++;
    if (sda !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_sda: got %b expected 1", sda); end
    testsRun++;
    if ({selected, read_mode, rx_valid, tx_load, start_detected, stop_detected, nack_received} !== 7'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got %b expected 0000000",
               {selected, read_mode, rx_valid, tx_load, start_detected, stop_detected, nack_received});
    end
    testsRun++;
    if (data_rx !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_data_rx: got %h expected 00", data_rx); end
    reset = 1'b0;
    #100ns;
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int st0 = startCount, sp0 = stopCount;
    rxQ.delete();
    bus_start();
    send_byte({ADDR, 1'b0}, a0);
    testsRun++;
    if (selected !== 1'b1 || read_mode !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL wr_sel_mode: got %b%b expected 10", selected, read_mode);
    end
    send_byte(8'hFE, a1);
    send_byte(8'hED, a2);
    testsRun++;
    if ({a0, a1, a2} !== 3'b111) begin testsFailed++; $display("[TB] FAIL wr_acks: got %b expected 111", {a0, a1, a2}); end
    testsRun++;
    if (selected !== 1'b1) begin testsFailed++; $display("[TB] FAIL wr_sel_hold: got %b expected 1", selected); end
    bus_stop();
    testsRun++;
    if (rxQ.size() != 2 || rxQ[0] !== 8'hFE || rxQ[1] !== 8'hED) begin
      testsFailed++; $display("[TB] FAIL wr_rx: got %p expected FE,ED", rxQ);
    end
    testsRun++;
    if (selected !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_sel_stop: got %b expected 0", selected); end
    testsRun++;
    if (startCount - st0 != 1 || stopCount - sp0 != 1) begin
      testsFailed++; $display("[TB] FAIL wr_start_stop: got %0d/%0d expected 1/1", startCount - st0, stopCount - sp0);
    end
  endtask

  task automatic test_read();
    logic a;
    logic [7:0] d0, d1;
    int tx0 = txCount, nk0 = nackCount;
    data_tx = 8'hCA;
    bus_start();
    send_byte({ADDR, 1'b1}, a);
    testsRun++;
    if (a !== 1'b1 || read_mode !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL rd_addr: got ack %b mode %b expected 1 1", a, read_mode);
    end
    recv_byte(1'b1, 8'hFE, d0);
    recv_byte(1'b0, 8'h00, d1);
    testsRun++;
    if (d0 !== 8'hCA) begin testsFailed++; $display("[TB] FAIL rd_byte0: got %h expected ca", d0); end
    testsRun++;
    if (d1 !== 8'hFE) begin testsFailed++; $display("[TB] FAIL rd_byte1: got %h expected fe", d1); end
    testsRun++;
    if (txCount - tx0 != 2 || nackCount - nk0 != 1) begin
      testsFailed++; $display("[TB] FAIL rd_pulses: got tx %0d nack %0d expected 2 1", txCount - tx0, nackCount - nk0);
    end
    testsRun++;
    if (sda !== 1'b1) begin testsFailed++; $display("[TB] FAIL rd_release: got %b expected 1", sda); end
    bus_stop();
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int rx0 = rxCount, tx0 = txCount;
    bus_start();
    send_byte(8'h42, a0);
    testsRun++;
    if (selected !== 1'b0) begin testsFailed++; $display("[TB] FAIL mm_sel: got %b expected 0", selected); end
    send_byte(8'h5A, a1);
    testsRun++;
    if ({a0, a1} !== 2'b00) begin testsFailed++; $display("[TB] FAIL mm_acks: got %b expected 00", {a0, a1}); end
    bus_stop();
    testsRun++;
    if (rxCount != rx0 || txCount != tx0) begin
      testsFailed++; $display("[TB] FAIL mm_pulses: got rx %0d tx %0d expected 0 0", rxCount - rx0, txCount - tx0);
    end
  endtask

  task automatic test_write_nack();
    logic a0, a1, a2;
    rxQ.delete();
    data_nack = 1'b0;
    bus_start();
    send_byte({ADDR, 1'b0}, a0);
    data_nack = 1'b1;
    send_byte(8'h11, a1);
    data_nack = 1'b0;
    send_byte(8'h22, a2);
    bus_stop();
    testsRun++;
    if ({a0, a1, a2} !== 3'b100) begin testsFailed++; $display("[TB] FAIL wn_acks: got %b expected 100", {a0, a1, a2}); end
    testsRun++;
    if (rxQ.size() != 1 || rxQ[0] !== 8'h11) begin testsFailed++; $display("[TB] FAIL wn_rx: got %p expected 11", rxQ); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2;
    logic [7:0] d;
    int st0 = startCount, tx0 = txCount;
    rxQ.delete();
    bus_start();
    send_byte({ADDR, 1'b0}, a0);
    testsRun++;
    if (read_mode !== 1'b0) begin testsFailed++; $display("[TB] FAIL rs_mode0: got %b expected 0", read_mode); end
    send_byte(8'hAB, a1);
    data_tx = 8'h3C;
    bus_start();
    send_byte({ADDR, 1'b1}, a2);
    testsRun++;
    if (read_mode !== 1'b1) begin testsFailed++; $display("[TB] FAIL rs_mode1: got %b expected 1", read_mode); end
    testsRun++;
    if (txCount - tx0 != 1) begin testsFailed++; $display("[TB] FAIL rs_txload: got %0d expected 1", txCount - tx0); end
    recv_byte(1'b0, 8'h00, d);
    bus_stop();
    testsRun++;
    if ({a0, a1, a2} !== 3'b111 || d !== 8'h3C) begin
      testsFailed++; $display("[TB] FAIL rs_data: got acks %b byte %h expected 111 3c", {a0, a1, a2}, d);
    end
    testsRun++;
    if (startCount - st0 != 2 || rxQ.size() != 1 || rxQ[0] !== 8'hAB) begin
      testsFailed++; $display("[TB] FAIL rs_counts: got starts %0d rx %p expected 2 AB", startCount - st0, rxQ);
    end
  endtask

  task automatic test_reset_mid_read();
    logic a, s;
    data_tx = 8'h00;
    bus_start();
    send_byte({ADDR, 1'b1}, a);
    for (int i = 0; i < 3; i++) send_bit(1'b1, s);
    testsRun++;
    if (sda !== 1'b0) begin testsFailed++; $display("[TB] FAIL mr_driving: got %b expected 0", sda); end
    #4ns;
    reset = 1'b1;
    #1ns;
    testsRun++;
    if (sda !== 1'b1) begin testsFailed++; $display("[TB] FAIL mr_release: got %b expected 1", sda); end
    testsRun++;
    if ({selected, read_mode, tx_load} !== 3'b000 || data_rx !== 8'h00) begin
      testsFailed++; $display("[TB] FAIL mr_outputs: got %b data %h expected 000 00", {selected, read_mode, tx_load}, data_rx);
    end
    #25ns;
    reset = 1'b0;
    #100ns;
    rxQ.delete();
    bus_start();
    send_byte({ADDR, 1'b0}, a);
    send_byte(8'h77, s);
    bus_stop();
    testsRun++;
    if ({a, s} !== 2'b11 || rxQ.size() != 1 || rxQ[0] !== 8'h77) begin
      testsFailed++; $display("[TB] FAIL mr_recover: got acks %b rx %p expected 11 77", {a, s}, rxQ);
    end
  endtask

  // Model: only ADDRESS (never 0) is ACKed; a write byte is received unless an
  // earlier byte was NACKed; a read returns data_tx bytes, else the idle bus (FF).
  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [6:0] a7;
      logic rw, addressed, gotAck, expAck, nackedBefore;
      logic [7:0] bytes[3];
      logic nackFlag[3];
      logic [7:0] got, expByte;
      logic [7:0] expRx[$];
      int n, tx0, nk0;
      case ($urandom_range(2, 0))
        0: a7 = ADDR;
        1: a7 = 7'h00;
        default: a7 = 7'($urandom_range(127, 0));
      endcase
      rw = 1'($urandom_range(1, 0));
      n = $urandom_range(3, 1);
      for (int k = 0; k < 3; k++) begin
        bytes[k] = 8'($urandom_range(255, 0));
        nackFlag[k] = ($urandom_range(3, 0) == 0);
      end
      addressed = (a7 == ADDR) && (a7 != 7'h00);
      rxQ.delete();
      expRx.delete();
      tx0 = txCount;
      nk0 = nackCount;
      data_tx = bytes[0];
      bus_start();
      send_byte({a7, rw}, gotAck);
      testsRun++;
      if (gotAck !== addressed) begin
        testsFailed++; $display("[TB] FAIL rnd_addr_ack[%0d]: got %b expected %b (addr %h)", t, gotAck, addressed, a7);
      end
      if (!rw) begin
        nackedBefore = 1'b0;
        for (int k = 0; k < n; k++) begin
          data_nack = nackFlag[k];
          send_byte(bytes[k], gotAck);
          expAck = addressed && !nackedBefore && !nackFlag[k];
          if (addressed && !nackedBefore) expRx.push_back(bytes[k]);
          nackedBefore = nackedBefore | nackFlag[k];
          testsRun++;
          if (gotAck !== expAck) begin
            testsFailed++; $display("[TB] FAIL rnd_wr_ack[%0d.%0d]: got %b expected %b", t, k, gotAck, expAck);
          end
        end
        data_nack = 1'b0;
      end else begin
        for (int k = 0; k < n; k++) begin
          recv_byte(k < n - 1, (k < n - 1) ? bytes[k + 1] : 8'h00, got);
          expByte = addressed ? bytes[k] : 8'hFF;
          testsRun++;
          if (got !== expByte) begin
            testsFailed++; $display("[TB] FAIL rnd_rd_byte[%0d.%0d]: got %h expected %h", t, k, got, expByte);
          end
        end
      end
      bus_stop();
      testsRun++;
      if (rxQ != expRx) begin testsFailed++; $display("[TB] FAIL rnd_rx[%0d]: got %p expected %p", t, rxQ, expRx); end
      testsRun++;
      if (txCount - tx0 != ((rw && addressed) ? n : 0) || nackCount - nk0 != ((rw && addressed) ? 1 : 0)) begin
        testsFailed++;
        $display("[TB] FAIL rnd_pulses[%0d]: got tx %0d nack %0d expected %0d %0d", t, txCount - tx0,
                 nackCount - nk0, (rw && addressed) ? n : 0, (rw && addressed) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_write_nack();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
